crossbar_shift_scheduler: RTL and testbench

- Produces the per-output `input_sel` / `output_enable` configuration that drives `crossbar_switch`.
- Per-output requests ("output o wants input i") are reduced to configurations that form a pure rotation. Every applied configuration is therefore barrel-shifter-legal and collision-free by construction.
- Requests that do not fit the chosen rotation are retained and served in later rounds.
- Rotation choice is max-match with round-robin tie-break, so every request is eventually served.

---
 rtl/crossbar_shift_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_crossbar_shift_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_shift_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crossbar_shift_scheduler                                                 |
// | Reduces per-output requests to rotation configurations for the crossbar |
// | switch. Optional statistics ports are enabled by XBAR_SCHED_STATS_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module crossbar_shift_scheduler #(
  parameter int N           = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_push,
  input  logic [N-1:0]              req_mask,
  input  logic [N*$clog2(N)-1:0]    req_sel,
  output logic                      req_ready,
  output logic [N*$clog2(N)-1:0]    input_sel,
  output logic [N-1:0]              output_enable,
  output logic                      cfg_valid,
  output logic [$clog2(N)-1:0]      cur_shift,
  output logic [N-1:0]              pending
`ifdef XBAR_SCHED_STATS_EN
  ,
  output logic [15:0]               round_count,
  output logic [15:0]               defer_count
`endif
);

  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SW-1:0] c_k_last    = SW'(N - 1);
  localparam logic [HW-1:0] c_hold_last = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [SW-1:0]   r_k;
  logic [SW-1:0]   r_rr_ptr;
  logic [SW-1:0]   r_best;
  logic [CW-1:0]   r_best_cnt;
  logic [HW-1:0]   r_hold;
  logic [N-1:0]    r_pending;
  logic [N*SW-1:0] r_req_sel;
  logic [N*SW-1:0] r_input_sel;
  logic [N-1:0]    r_output_enable;
  logic            r_cfg_valid;
  logic [SW-1:0]   r_cur_shift;

  logic [SW-1:0]   w_scan_shift;
  logic [CW-1:0]   w_scan_cnt;
  logic [CW-1:0]   w_prev_cnt;
  logic [SW-1:0]   w_prev_best;
  logic            w_take;
  logic [SW-1:0]   w_best_next;
  logic [CW-1:0]   w_best_cnt_next;
  logic [N-1:0]    w_grant;
  logic [N-1:0]    w_pending_left;
  logic [N*SW-1:0] w_rot_sel;
  logic            w_accept;
  logic            w_eval_done;
  logic            w_hold_done;

  function automatic logic [N-1:0] match_vec(input logic [N*SW-1:0] sel,
                                             input logic [SW-1:0]   s);
    logic [N-1:0] m;
    m = '0;
    for (int o = 0; o < N; o++) begin
      m[o] = (sel[o*SW +: SW] == SW'(o) + s);
    end
    return m;
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int o = 0; o < N; o++) begin
      c = c + CW'(v[o]);
    end
    return c;
  endfunction

  // Scan index 0 restarts the max search; strict compare keeps the earliest shift on ties.
  assign w_scan_shift    = r_rr_ptr + r_k;
  assign w_scan_cnt      = popcnt(r_pending & match_vec(r_req_sel, w_scan_shift));
  assign w_prev_cnt      = (r_k == '0) ? '0 : r_best_cnt;
  assign w_prev_best     = (r_k == '0) ? w_scan_shift : r_best;
  assign w_take          = (w_scan_cnt > w_prev_cnt);
  assign w_best_next     = w_take ? w_scan_shift : w_prev_best;
  assign w_best_cnt_next = w_take ? w_scan_cnt : w_prev_cnt;
  assign w_grant         = r_pending & match_vec(r_req_sel, w_best_next);
  assign w_pending_left  = r_pending & ~r_output_enable;

  assign req_ready   = (r_state == S_IDLE) && !rst;
  assign w_accept    = req_push && req_ready;
  assign w_eval_done = (r_state == S_EVAL) && (r_k == c_k_last);
  assign w_hold_done = (r_state == S_APPLY) && (r_hold == c_hold_last);

  generate
    for (genvar o = 0; o < N; o++) begin : g_rot
      assign w_rot_sel[o*SW +: SW] = SW'(o) + w_best_next;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (|req_mask)) w_state_next = S_EVAL;
      S_EVAL:  if (r_k == c_k_last) w_state_next = S_APPLY;
      S_APPLY: if (r_hold == c_hold_last) w_state_next = (|w_pending_left) ? S_EVAL : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k             <= '0;
      r_rr_ptr        <= '0;
      r_best          <= '0;
      r_best_cnt      <= '0;
      r_hold          <= '0;
      r_pending       <= '0;
      r_req_sel       <= '0;
      r_input_sel     <= '0;
      r_output_enable <= '0;
      r_cfg_valid     <= 1'b0;
      r_cur_shift     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (|req_mask)) begin
            r_pending <= req_mask;
            r_req_sel <= req_sel;
            r_k       <= '0;
          end
        end
        S_EVAL: begin
          r_k        <= r_k + SW'(1);
          r_best     <= w_best_next;
          r_best_cnt <= w_best_cnt_next;
          if (w_eval_done) begin
            r_cur_shift     <= w_best_next;
            r_input_sel     <= w_rot_sel;
            r_output_enable <= w_grant;
            r_cfg_valid     <= 1'b1;
            r_rr_ptr        <= w_best_next + SW'(1);
            r_hold          <= '0;
          end
        end
        S_APPLY: begin
          r_hold <= r_hold + HW'(1);
          if (w_hold_done) begin
            r_cfg_valid     <= 1'b0;
            r_output_enable <= '0;
            r_pending       <= w_pending_left;
            r_k             <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign input_sel     = r_input_sel;
  assign output_enable = r_output_enable;
  assign cfg_valid     = r_cfg_valid;
  assign cur_shift     = r_cur_shift;
  assign pending       = r_pending;

`ifdef XBAR_SCHED_STATS_EN
  logic [15:0] r_round_count;
  logic [15:0] r_defer_count;
  logic [16:0] w_defer_sum;

  assign w_defer_sum = {1'b0, r_defer_count} + 17'(popcnt(w_pending_left));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_round_count <= '0;
      r_defer_count <= '0;
    end else begin
      if (w_eval_done && (r_round_count != 16'hFFFF)) begin
        r_round_count <= r_round_count + 16'd1;
      end
      if (w_hold_done) begin
        r_defer_count <= w_defer_sum[16] ? 16'hFFFF : w_defer_sum[15:0];
      end
    end
  end

  assign round_count = r_round_count;
  assign defer_count = r_defer_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crossbar_shift_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_crossbar_shift_scheduler                                              |
// | Randomized and directed bench for crossbar_shift_scheduler.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_crossbar_shift_scheduler;

  localparam int N    = 8;
  localparam int HOLD = 4;
  localparam int SW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_push;
  logic [N-1:0]    req_mask;
  logic [N*SW-1:0] req_sel;
  logic            req_ready;
  logic [N*SW-1:0] input_sel;
  logic [N-1:0]    output_enable;
  logic            cfg_valid;
  logic [SW-1:0]   cur_shift;
  logic [N-1:0]    pending;
`ifdef XBAR_SCHED_STATS_EN
  logic [15:0]     round_count;
  logic [15:0]     defer_count;
`endif

  crossbar_shift_scheduler #(.N(N), .HOLD_CYCLES(HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_push      (req_push),
    .req_mask      (req_mask),
    .req_sel       (req_sel),
    .req_ready     (req_ready),
    .input_sel     (input_sel),
    .output_enable (output_enable),
    .cfg_valid     (cfg_valid),
    .cur_shift     (cur_shift),
    .pending       (pending)
`ifdef XBAR_SCHED_STATS_EN
    ,
    .round_count   (round_count),
    .defer_count   (defer_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_rr  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: scan shifts starting at the round-robin pointer, keep the first max count.
  function automatic int ref_shift(input logic [N-1:0] pend, input logic [N*SW-1:0] sel, input int rr);
    int bc = 0;
    int b  = rr;
    for (int k = 0; k < N; k++) begin
      int s = (rr + k) % N;
      int c = 0;
      for (int o = 0; o < N; o++) begin
        if (pend[o] && int'(sel[o*SW +: SW]) == (o + s) % N) c++;
      end
      if (c > bc) begin
        bc = c;
        b  = s;
      end
    end
    return b;
  endfunction

  function automatic logic [N-1:0] ref_grant(input logic [N-1:0] pend, input logic [N*SW-1:0] sel, input int s);
    logic [N-1:0] g = '0;
    for (int o = 0; o < N; o++) g[o] = pend[o] && (int'(sel[o*SW +: SW]) == (o + s) % N);
    return g;
  endfunction

  function automatic logic [N*SW-1:0] rot_sel(input int sh);
    logic [N*SW-1:0] v;
    for (int o = 0; o < N; o++) v[o*SW +: SW] = SW'((o + sh) % N);
    return v;
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    req_push = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_enable", output_enable, 0);
    chk("rst_pending", pending, 0);
    chk("rst_shift", cur_shift, 0);
    chk("rst_insel", input_sel, 0);
    rst = 1'b0;
    #1 chk("rst_ready", req_ready, 1);
    m_rr = 0;
  endtask

  task automatic run_req(input logic [N-1:0] mask, input logic [N*SW-1:0] sel,
                         input bit poke_eval, input bit abort);
    logic [N-1:0]    pend;
    logic [N-1:0]    g;
    logic [N*SW-1:0] exp_is;
    int              s;
    int              cyc;
    pend = mask;
    chk("ready_idle", req_ready, 1);
    req_push = 1'b1;
    req_mask = mask;
    req_sel  = sel;
    @(negedge clk);
    req_push = 1'b0;
    cyc = 0;
    if (poke_eval) begin
      req_push = 1'b1;
      req_mask = ~mask;
      req_sel  = ~sel;
      #1 chk("ready_busy", req_ready, 0);
      @(negedge clk);
      req_push = 1'b0;
      cyc = 1;
    end
    while (pend != '0) begin
      while (!cfg_valid && cyc < 4 * N) begin
        @(negedge clk);
        cyc++;
      end
      chk("latency", cyc, N);
      s      = ref_shift(pend, sel, m_rr);
      g      = ref_grant(pend, sel, s);
      exp_is = rot_sel(s);
      chk("shift", cur_shift, s);
      chk("enable", output_enable, g);
      chk("insel", input_sel, exp_is);
      chk("pend_apply", pending, pend);
      m_rr = (s + 1) % N;
      pend = pend & ~g;
      if (abort) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cfg_valid", cfg_valid, 0);
        chk("abort_enable", output_enable, 0);
        chk("abort_pending", pending, 0);
        rst = 1'b0;
        #1 chk("abort_ready", req_ready, 1);
        m_rr = 0;
        cyc = 0;
        repeat (N + HOLD + 2) begin
          @(negedge clk);
          if (cfg_valid) cyc++;
        end
        chk("abort_quiet", cyc, 0);
        return;
      end
      cyc = 0;
      while (cfg_valid && cyc < 4 * HOLD) begin
        @(negedge clk);
        cyc++;
      end
      chk("hold", cyc, HOLD);
      chk("pend_left", pending, pend);
      chk("enable_off", output_enable, 0);
      chk("insel_kept", input_sel, exp_is);
      cyc = 0;
    end
    chk("ready_done", req_ready, 1);
  endtask

  initial begin
    logic [N*SW-1:0] sel;
    logic [N-1:0]    mask;
    int              cyc;
    rst      = 1'b1;
    req_push = 1'b0;
    req_mask = '0;
    req_sel  = '0;
    do_reset();

    // Null push in IDLE.
    req_push = 1'b1;
    req_mask = '0;
    req_sel  = rot_sel(2);
    @(negedge clk);
    req_push = 1'b0;
    chk("null_ready", req_ready, 1);
    chk("null_pending", pending, 0);
    cyc = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (cfg_valid) cyc++;
    end
    chk("null_quiet", cyc, 0);

    run_req(8'hFF, rot_sel(0), 1'b0, 1'b0);
    run_req(8'hFF, rot_sel(3), 1'b0, 1'b0);
    sel = '0;
    for (int o = 0; o < N; o++) sel[o*SW +: SW] = SW'((o < 4) ? o + 1 : o + 2);
    run_req(8'h3F, sel, 1'b1, 1'b0);

    do_reset();
    sel = '0;
    sel[1*SW +: SW] = 3'd3;
    run_req(8'h03, sel, 1'b0, 1'b0);
    run_req(8'h03, sel, 1'b0, 1'b0);

    run_req(8'hFF, rot_sel(5), 1'b0, 1'b1);

    for (int t = 0; t < 25; t++) begin
      mask = N'($urandom_range(1, 255));
      if (t % 2 == 0) begin
        sel = N*SW'($urandom);
      end else begin
        for (int o = 0; o < N; o++) sel[o*SW +: SW] = SW'(o + 3 * $urandom_range(0, 2));
      end
      run_req(mask, sel, (t % 5 == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
